// File: rtl/crossbars_pkg.sv
// crossbars_pkg: shared FSM state type and control-word width helper for the crossbar route sequencer.
package crossbars_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;
  // A degenerate 1x1 crossbar still carries a one-bit control word.
  function automatic int ctrl_width(input int n_in, input int n_out);
    return (n_in * n_out > 1) ? $clog2(n_in * n_out) : 1;
  endfunction
endpackage

// File: rtl/crossbars_route_table.sv
// crossbars_route_table: DEPTH-entry schedule store with write pointer, entry count, full/empty and clear.
module crossbars_route_table #(
  parameter int DEPTH = 4,
  parameter int W = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          clear,
  input  logic [AW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = wr_en && !full && !clear;
  assign rd_data = mem[rd_idx];
  always_ff @(posedge clk)
    if (!reset || clear) begin
      count <= '0;
      wr_ptr <= '0;
    end else if (wr) begin
      count <= count + (AW+1)'(1);
      wr_ptr <= wr_ptr + AW'(1);
    end
  // Storage is left unreset; the zeroed count makes stale entries unreachable.
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/crossbars_route_sequencer.sv
// crossbars_route_sequencer: steps a crossbar through a programmed table of {route, transfer count} entries.
module crossbars_route_sequencer import crossbars_pkg::*; #(
  parameter int N_INPUTS = 2,
  parameter int N_OUTPUTS = 2,
  parameter int DEPTH = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int CONTROL_BIT_WIDTH = ctrl_width(N_INPUTS, N_OUTPUTS),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CONTROL_BIT_WIDTH+COUNT_WIDTH-1:0] cfg_msg,
  input  logic                                 cfg_val,
  output logic                                 cfg_rdy,
  input  logic                                 clear,
  input  logic                                 start,
  input  logic                                 loop,
  input  logic                                 abort,
  output logic [CONTROL_BIT_WIDTH-1:0]         control,
  output logic                                 control_val,
  input  logic                                 control_rdy,
  input  logic                                 xfer_val,
  input  logic                                 xfer_rdy,
  output logic                                 busy,
  output logic                                 done,
  output logic [IW-1:0]                        entry_idx,
  output logic [COUNT_WIDTH-1:0]               remaining
);
  localparam int W = CONTROL_BIT_WIDTH + COUNT_WIDTH;
  state_t state, state_n;
  logic [IW-1:0] idx_n;
  logic [COUNT_WIDTH-1:0] rem_n, ent_cnt;
  logic [W-1:0] entry;
  logic [IW:0] count;
  logic full, empty, idle, last, fire, adv;
  assign idle = state == IDLE;
  assign cfg_rdy = idle && !full;
  crossbars_route_table #(.DEPTH(DEPTH), .W(W)) u_table (
    .clk(clk), .reset(reset), .wr_en(cfg_val && cfg_rdy), .wr_data(cfg_msg),
    .clear(idle && clear), .rd_idx(entry_idx), .rd_data(entry),
    .count(count), .full(full), .empty(empty)
  );
  assign ent_cnt = entry[COUNT_WIDTH-1:0];
  assign last = {1'b0, entry_idx} == count - (IW+1)'(1);
  assign fire = xfer_val && xfer_rdy;
  // An entry ends on its final counted transfer, or at the handshake itself when its count is zero.
  assign adv = (state == ISSUE && control_rdy && ent_cnt == '0) ||
               (state == RUN && fire && remaining == COUNT_WIDTH'(1));
  assign control_val = state == ISSUE && !abort;
  assign control = control_val ? entry[W-1 -: CONTROL_BIT_WIDTH] : '0;
  assign busy = !idle;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    idx_n = entry_idx;
    rem_n = remaining;
    if (abort) begin
      state_n = IDLE;
      idx_n = '0;
      rem_n = '0;
    end else if (adv) begin
      state_n = (!last || loop) ? ISSUE : DONE;
      idx_n = !last ? entry_idx + IW'(1) : loop ? '0 : entry_idx;
      rem_n = '0;
    end else if (idle && start && !clear && !empty) begin
      state_n = ISSUE;
      idx_n = '0;
    end else if (state == ISSUE && control_rdy) begin
      state_n = RUN;
      rem_n = ent_cnt;
    end else if (state == RUN && fire) begin
      rem_n = remaining - COUNT_WIDTH'(1);
    end else if (done) begin
      state_n = IDLE;
      idx_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      entry_idx <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      entry_idx <= idx_n;
      remaining <= rem_n;
    end
endmodule

// File: doc/crossbars_route_sequencer.md
CROSSBARS_ROUTE_SEQUENCER -- requirements
Module: crossbars_route_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 2, meaning crossbar input count.
REQ-002 SHALL have parameter N_OUTPUTS, default 2, meaning crossbar output count.
REQ-003 SHALL have parameter DEPTH, default 4, meaning number of schedule entries (power of 2, >=2).
REQ-004 SHALL have parameter COUNT_WIDTH, default 8, meaning width of per-entry transfer count.
REQ-005 SHALL derive localparam CONTROL_BIT_WIDTH = $clog2(N_INPUTS*N_OUTPUTS); the control word is {input_sel, output_sel}, MSB-aligned, matching the crossbar's encoding.
REQ-006 SHALL have the following ports; one clock; reset is synchronous and active-low:
  clk  input  1  sole clock, all state on posedge.
  reset  input  1  synchronous active-low reset (0 = reset).
  cfg_msg  input  CONTROL_BIT_WIDTH+COUNT_WIDTH  entry write, {control, count}.
  cfg_val  input  1  entry write valid.
  cfg_rdy  output  1  entry write ready.
  clear  input  1  empty the schedule table (honoured in IDLE only).
  start  input  1  begin executing the table (honoured in IDLE only).
  loop  input  1  sampled at end of last entry; 1 = restart at entry 0.
  abort  input  1  return to IDLE from any state.
  control  output  CONTROL_BIT_WIDTH  route word to crossbar.
  control_val  output  1  route word valid.
  control_rdy  input  1  crossbar accepts route word.
  xfer_val  input  1  monitored val of crossbar's selected output.
  xfer_rdy  input  1  monitored rdy of crossbar's selected output.
  busy  output  1  high in any state other than IDLE.
  done  output  1  one-cycle pulse on schedule completion.
  entry_idx  output  $clog2(DEPTH)  index of the entry being executed.
  remaining  output  COUNT_WIDTH  transfers left in the current entry.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, RUN, DONE.
REQ-008 IDLE: cfg_rdy = !full; a cfg fire (cfg_val && cfg_rdy) writes entry[wr_ptr] and increments the entry count; cfg_rdy SHALL be 0 in all other states.
REQ-009 IDLE: clear SHALL zero the entry count next cycle; clear has priority over a same-cycle cfg write and over start.
REQ-010 IDLE: start with entry count > 0 SHALL go to ISSUE with entry_idx = 0; start with empty table SHALL be ignored (no done).
REQ-011 ISSUE: control_val = 1 and control = entry[entry_idx].control; on control_rdy, load remaining = entry count field and go to RUN, or advance directly (REQ-013) if the count field is 0.
REQ-012 RUN: each cycle with xfer_val && xfer_rdy SHALL decrement remaining by 1; fires outside RUN are ignored.
REQ-013 Advance (fire with remaining == 1, or zero-count entry): if entry_idx < count-1, increment entry_idx and go to ISSUE; else if loop = 1, set entry_idx = 0 and go to ISSUE; else go to DONE.
REQ-014 DONE: done = 1 for exactly one cycle, then IDLE; entry_idx returns to 0.
REQ-015 Latency: a control handshake in cycle t SHALL allow counted transfers from cycle t+1.
REQ-016 abort SHALL take precedence over all transitions: next state IDLE, control_val = 0, remaining = 0, no done pulse, table contents retained.
REQ-017 control SHALL be 0 whenever control_val = 0.
REQ-018 Table contents SHALL persist across runs until clear or reset.

Reset
REQ-019 With reset = 0 at posedge: state IDLE, entry count 0, wr_ptr 0, entry_idx 0, remaining 0, control 0, control_val 0, done 0, busy 0; cfg_rdy SHALL be 1 in the first cycle after reset is released.
REQ-020 Reset asserted mid-run SHALL discard the table and all progress; table storage contents need not be reset.

Structure
REQ-021 Package crossbars_pkg SHALL hold the FSM state enum and a helper function computing CONTROL_BIT_WIDTH.
REQ-022 The schedule storage SHALL be a sub-module crossbars_route_table (DEPTH x entry registers, write pointer, count, full/empty flags, clear).

Verification
REQ-023 Write {2'b10, 8'd3}, {2'b01, 8'd2}, start, control_rdy = 1, xfer always firing -> control 2'b10 for 3 fires, then 2'b01 for 2 fires, done pulses once, busy falls the next cycle.
REQ-024 Write 4 entries (DEPTH = 4) -> cfg_rdy = 0 after the 4th write; a 5th cfg_val is not accepted; clear -> cfg_rdy = 1, and start is then ignored.
REQ-025 Entry {2'b11, 8'd0} between two count-1 entries -> control 2'b11 issued for one handshake, no RUN cycles, then the next entry is issued.
REQ-026 loop = 1, two entries of count 1 -> entry_idx sequence 0,1,0,1,... with no done; drop loop during entry 1 -> done after entry 1.
REQ-027 Abort in RUN with remaining = 5 -> IDLE next cycle, remaining 0, no done; start again -> reissue from entry 0.
REQ-028 control_rdy held 0 for 3 cycles in ISSUE, xfer firing -> control_val stays 1, remaining unchanged until the handshake.
